// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-ported data memory between two req/ack ports
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nx;
    logic owner, lat_we, last_grant, grant1, acc;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    // next state, tie-break winner and memory/ack drive; reset blocks any write or ack this cycle
    always_comb begin
        grant1    = req1 & (~req0 | ~last_grant);
        state_nx  = state == IDLE ? ((req0 | req1) ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
        acc       = (state == ACCESS) & ~reset;
        mem_we    = acc & lat_we;
        mem_re    = acc & ~lat_we;
        mem_addr  = acc ? lat_addr : '0;
        mem_wdata = acc ? lat_wdata : '0;
        ack0      = (state == DONE) & ~reset & ~owner;
        ack1      = (state == DONE) & ~reset & owner;
    end
    // state register, grant latch, read capture and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_grant <= 1'b1;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_nx;
            busy  <= state_nx != IDLE;
            if (state == IDLE && (req0 | req1)) begin
                owner     <= grant1;
                lat_we    <= grant1 ? we1 : we0;
                lat_addr  <= grant1 ? addr1 : addr0;
                lat_wdata <= grant1 ? wdata1 : wdata0;
            end
            if (state == ACCESS && !lat_we && owner) rdata1 <= mem_rdata;
            if (state == ACCESS && !lat_we && !owner) rdata0 <= mem_rdata;
            if (state == DONE) last_grant <= owner;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a behavioural memory
module tb_dmem_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic ack0, ack1, busy, mem_we, mem_re;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];
    int checks = 0, failures = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_re ? mem[mem_addr] : 8'h00;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic port, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                       output int lat, output logic [7:0] rd);
        lat = -1;
        rd = 8'h00;
        if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
        else begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (port ? ack1 : ack0) begin
                lat = c;
                rd = port ? rdata1 : rdata0;
                break;
            end
            step();
        end
        if (port) req1 = 0; else req0 = 0;
        step();
    endtask

    task automatic test_reset;
        reset = 1; req0 = 1; we0 = 1; addr0 = 8'h44; wdata0 = 8'h99;
        step(); step(); @(negedge clk);
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL rst_ack0 got %b exp 0", ack0); end
        checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL rst_ack1 got %b exp 0", ack1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (rdata0 !== 8'h00) begin failures++; $display("FAIL rst_rdata0 got %h exp 00", rdata0); end
        checks++; if (rdata1 !== 8'h00) begin failures++; $display("FAIL rst_rdata1 got %h exp 00", rdata1); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rst_mem_re got %b exp 0", mem_re); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL rst_mem_addr got %h exp 00", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL rst_mem_wdata got %h exp 00", mem_wdata); end
        step();
        req0 = 0; reset = 0;
    endtask

    task automatic test_write;
        step();
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_c0_busy got %b exp 0", busy); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wr_c0_mem_we got %b exp 0", mem_we); end
        step(); @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL wr_c1_mem_we got %b exp 1", mem_we); end
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL wr_c1_mem_re got %b exp 0", mem_re); end
        checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL wr_c1_mem_addr got %h exp 10", mem_addr); end
        checks++; if (mem_wdata !== 8'hA5) begin failures++; $display("FAIL wr_c1_mem_wdata got %h exp a5", mem_wdata); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_c1_busy got %b exp 1", busy); end
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL wr_c1_ack0 got %b exp 0", ack0); end
        step(); @(negedge clk);
        checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL wr_c2_ack0 got %b exp 1", ack0); end
        checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL wr_c2_ack1 got %b exp 0", ack1); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_c2_busy got %b exp 1", busy); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wr_c2_mem_we got %b exp 0", mem_we); end
        req0 = 0;
        step(); @(negedge clk);
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL wr_c3_ack0 got %b exp 0", ack0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_c3_busy got %b exp 0", busy); end
        checks++; if (mem[8'h10] !== 8'hA5) begin failures++; $display("FAIL wr_mem10 got %h exp a5", mem[8'h10]); end
    endtask

    task automatic test_read;
        step();
        req1 = 1; we1 = 0; addr1 = 8'h10;
        @(negedge clk);
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rd_c0_mem_re got %b exp 0", mem_re); end
        step(); @(negedge clk);
        checks++; if (mem_re !== 1'b1) begin failures++; $display("FAIL rd_c1_mem_re got %b exp 1", mem_re); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_c1_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL rd_c1_mem_addr got %h exp 10", mem_addr); end
        step(); @(negedge clk);
        checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL rd_c2_ack1 got %b exp 1", ack1); end
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL rd_c2_ack0 got %b exp 0", ack0); end
        checks++; if (rdata1 !== 8'hA5) begin failures++; $display("FAIL rd_rdata1 got %h exp a5", rdata1); end
        checks++; if (rdata0 !== 8'h00) begin failures++; $display("FAIL rd_rdata0 got %h exp 00", rdata0); end
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rd_c2_mem_re got %b exp 0", mem_re); end
        req1 = 0;
    endtask

    task automatic test_round_robin;
        int ports [4] = '{-1, -1, -1, -1};
        int cyc [4] = '{-1, -1, -1, -1};
        int nacks = 0;
        step();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        req1 = 1; we1 = 1; addr1 = 8'h11; wdata1 = 8'h22;
        for (int c = 0; c < 20 && nacks < 4; c++) begin
            @(negedge clk);
            checks++; if ((ack0 & ack1) !== 1'b0) begin failures++; $display("FAIL rr_dual_ack cycle %0d got 1 exp 0", c); end
            if (ack0 | ack1) begin
                ports[nacks] = int'(ack1);
                cyc[nacks] = c;
                nacks++;
            end
            if (nacks == 4) begin req0 = 0; req1 = 0; end
            else step();
        end
        req0 = 0; req1 = 0;
        checks++; if (nacks !== 4) begin failures++; $display("FAIL rr_ack_count got %0d exp 4", nacks); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ports[i] !== i % 2) begin failures++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, ports[i], i % 2); end
            checks++; if (cyc[i] !== 2 + 3 * i) begin failures++; $display("FAIL rr_cycle[%0d] got %0d exp %0d", i, cyc[i], 2 + 3 * i); end
        end
        checks++; if (rdata0 !== 8'hA5) begin failures++; $display("FAIL rr_rdata0 got %h exp a5", rdata0); end
        checks++; if (mem[8'h11] !== 8'h22) begin failures++; $display("FAIL rr_mem11 got %h exp 22", mem[8'h11]); end
    endtask

    task automatic test_boundary;
        int lat;
        logic [7:0] rd;
        step();
        txn(1'b0, 1'b1, 8'h00, 8'h5A, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL bnd_wr00_lat got %0d exp 2", lat); end
        txn(1'b0, 1'b1, 8'hFF, 8'hFF, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL bnd_wrff_lat got %0d exp 2", lat); end
        checks++; if (mem[8'hFF] !== 8'hFF) begin failures++; $display("FAIL bnd_memff got %h exp ff", mem[8'hFF]); end
        txn(1'b0, 1'b0, 8'hFF, 8'h00, lat, rd);
        checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL bnd_rdff got %h exp ff", rd); end
        txn(1'b0, 1'b0, 8'h00, 8'h00, lat, rd);
        checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL bnd_rd00 got %h exp 5a", rd); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL bnd_rd00_lat got %0d exp 2", lat); end
        checks++; if (rdata1 !== 8'hA5) begin failures++; $display("FAIL bnd_rdata1_kept got %h exp a5", rdata1); end
    endtask

    task automatic test_reset_abort;
        int lat;
        logic [7:0] rd;
        step();
        txn(1'b1, 1'b1, 8'h20, 8'h77, lat, rd);
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h3C;
        step();
        reset = 1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ab_c1_mem_we got %b exp 0", mem_we); end
        step();
        reset = 0;
        @(negedge clk);
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL ab_c2_ack0 got %b exp 0", ack0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_c2_busy got %b exp 0", busy); end
        checks++; if (mem[8'h20] !== 8'h77) begin failures++; $display("FAIL ab_mem20_kept got %h exp 77", mem[8'h20]); end
        checks++; if (rdata1 !== 8'h00) begin failures++; $display("FAIL ab_rdata1_rst got %h exp 00", rdata1); end
        step(); @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ab_c3_mem_we got %b exp 1", mem_we); end
        checks++; if (mem_wdata !== 8'h3C) begin failures++; $display("FAIL ab_c3_mem_wdata got %h exp 3c", mem_wdata); end
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL ab_c3_ack0 got %b exp 0", ack0); end
        step(); @(negedge clk);
        checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL ab_c4_ack0 got %b exp 1", ack0); end
        checks++; if (mem[8'h20] !== 8'h3C) begin failures++; $display("FAIL ab_mem20 got %h exp 3c", mem[8'h20]); end
        req0 = 0;
    endtask

    task automatic test_ignore_req1;
        step();
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'h11;
        @(negedge clk);
        checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL ig_c0_ack1 got %b exp 0", ack1); end
        step();
        req1 = 1; we1 = 0; addr1 = 8'h30;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ig_c1_mem_we got %b exp 1", mem_we); end
        checks++; if (mem_addr !== 8'h30) begin failures++; $display("FAIL ig_c1_mem_addr got %h exp 30", mem_addr); end
        step();
        req1 = 0;
        @(negedge clk);
        checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL ig_c2_ack0 got %b exp 1", ack0); end
        checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL ig_c2_ack1 got %b exp 0", ack1); end
        step();
        req1 = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ig_c3_busy got %b exp 0", busy); end
        step(); @(negedge clk);
        checks++; if (mem_re !== 1'b1) begin failures++; $display("FAIL ig_c4_mem_re got %b exp 1", mem_re); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ig_c4_mem_we got %b exp 0", mem_we); end
        step(); @(negedge clk);
        checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL ig_c5_ack1 got %b exp 1", ack1); end
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL ig_c5_ack0 got %b exp 0", ack0); end
        checks++; if (rdata1 !== 8'h11) begin failures++; $display("FAIL ig_rdata1 got %h exp 11", rdata1); end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_boundary();
        test_reset_abort();
        test_ignore_req1();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
